// File: rtl/hex_bcd_pkg.sv
// Shared types and constants for hex_bcd_display: FSM state encoding,
// blank/minus segment patterns, the 0-F glyph table, and a digit-count helper.
// Segments are active-low; bit i drives segment f_i (a..g = f0..f6).
package hex_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Glyphs 0123456789AbCdEF, active-low.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Number of decimal digits needed to print v.
  function automatic int dec_digits(input longint unsigned v);
    int              n;
    longint unsigned r;
    n = 1;
    r = v;
    for (int unsigned i = 0; i < 20; i++) begin
      if (r >= 64'd10) begin
        r = r / 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit nibble to active-low seven-segment glyph decoder.
module seg7_decode
  import hex_bcd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the hex glyph for this nibble.
  always_comb begin
    seg = GLYPH[nibble];
  end

endmodule

// File: rtl/hex_bcd_display.sv
// Multi-channel value display: selects one of NUM_CH values with a push-key,
// converts it to BCD (double dabble) or passes it through as hex, and drives
// NUM_DIGITS active-low seven-segment digits.
// Optional macro HEX_BCD_SIGNED_EN: decimal mode treats values as two's
// complement and shows a leading minus on the most significant digit.
module hex_bcd_display
  import hex_bcd_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int VAL_W      = 10,
  parameter int NUM_DIGITS = 4
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_CH*VAL_W-1:0]   values,
  input  logic                      change,
  input  logic                      hex_mode,
  output logic [NUM_DIGITS*7-1:0]   seg,
  output logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic                      busy
);

  localparam int CH_W     = $clog2(NUM_CH);
  localparam int DIG_W    = 4 * NUM_DIGITS;
  localparam int CNT_W    = $clog2(VAL_W + 1);
  localparam int HEX_NEED = (VAL_W + 3) / 4;
`ifdef HEX_BCD_SIGNED_EN
  localparam int DEC_NEED = dec_digits(64'd1 << (VAL_W - 1)) + 1;
`else
  localparam int DEC_NEED = dec_digits((64'd1 << VAL_W) - 64'd1);
`endif

  // NUM_CH below 2 would give ch_sel a zero width, so it is rejected too.
  if ((NUM_DIGITS < DEC_NEED) || (NUM_DIGITS < HEX_NEED) || (NUM_CH < 2)) begin : g_bad_cfg
    $error("hex_bcd_display: NUM_DIGITS too small for VAL_W, or NUM_CH < 2");
  end

  state_e                  state_q, state_d;
  logic                    sync1_q, sync2_q, prev_q;
  logic                    change_edge;
  logic [CH_W-1:0]         ch_sel_q, ch_sel_d;
  logic [VAL_W-1:0]        val_q, val_d, chan_val;
  logic [DIG_W-1:0]        bcd_q, bcd_d, bcd_adj;
  logic                    hex_q, hex_d;
  logic                    neg_q, neg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_DIGITS*7-1:0] seg_q, seg_d, glyphs;
  logic                    busy_q, busy_d;

  assign change_edge = sync2_q & ~prev_q;
  assign chan_val    = values[int'(ch_sel_q) * VAL_W +: VAL_W];

  // One glyph decoder per digit of the BCD/hex result register.
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dec
    seg7_decode u_dec (
      .nibble (bcd_q[d*4 +: 4]),
      .seg    (glyphs[d*7 +: 7])
    );
  end

  // Add-3 correction of every BCD nibble >= 5 ahead of the shift (decimal only).
  always_comb begin
    bcd_adj = bcd_q;
    if (!hex_q) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (bcd_q[i*4 +: 4] >= 4'd5) begin
          bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
      end
    end
  end

  // Channel select, FSM next state and conversion datapath.
  always_comb begin
    state_d  = state_q;
    ch_sel_d = ch_sel_q;
    val_d    = val_q;
    bcd_d    = bcd_q;
    hex_d    = hex_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    seg_d    = seg_q;

    if (change_edge) begin
      ch_sel_d = (ch_sel_q == CH_W'(NUM_CH - 1)) ? '0 : ch_sel_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        state_d = LOAD;
      end
      LOAD: begin
        val_d = chan_val;
        bcd_d = '0;
        hex_d = hex_mode;
        neg_d = 1'b0;
        cnt_d = '0;
`ifdef HEX_BCD_SIGNED_EN
        if (!hex_mode && chan_val[VAL_W-1]) begin
          neg_d = 1'b1;
          val_d = ~chan_val + 1'b1;
        end
`endif
        state_d = SHIFT;
      end
      SHIFT: begin
        if (change_edge) begin
          // ch_sel_q already holds the new channel when LOAD runs.
          state_d = LOAD;
        end else begin
          {bcd_d, val_d} = {bcd_adj[DIG_W-2:0], val_q, 1'b0};
          cnt_d          = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(VAL_W - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        seg_d = glyphs;
        if (neg_q) begin
          seg_d[(NUM_DIGITS-1)*7 +: 7] = SEG_MINUS;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == LOAD) || (state_d == SHIFT);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      ch_sel_q <= '0;
      val_q    <= '0;
      bcd_q    <= '0;
      hex_q    <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      seg_q    <= {NUM_DIGITS{SEG_BLANK}};
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= change;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      ch_sel_q <= ch_sel_d;
      val_q    <= val_d;
      bcd_q    <= bcd_d;
      hex_q    <= hex_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      seg_q    <= seg_d;
      busy_q   <= busy_d;
    end
  end

  assign seg    = seg_q;
  assign ch_sel = ch_sel_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_hex_bcd_display.sv
// Self-checking bench for hex_bcd_display (default parameters).
`timescale 1ns/1ps
module tb_hex_bcd_display;

  localparam int NUM_CH     = 3;
  localparam int VAL_W      = 10;
  localparam int NUM_DIGITS = 4;
  localparam logic [27:0] ALL_BLANK = '1;

  logic        clock    = 1'b0;
  logic        resetn   = 1'b0;
  logic        change   = 1'b0;
  logic        hex_mode = 1'b0;
  logic [29:0] values   = '0;
  logic [27:0] seg;
  logic [1:0]  ch_sel;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [27:0] exp_q[$];
  logic [27:0] shown;

  typedef struct {
    logic [9:0]  val;
    logic        hexm;
    logic [15:0] dig;
    logic        neg;
  } vec_t;
  vec_t vecs[$];

  hex_bcd_display #(
    .NUM_CH     (NUM_CH),
    .VAL_W      (VAL_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .values   (values),
    .change   (change),
    .hex_mode (hex_mode),
    .seg      (seg),
    .ch_sel   (ch_sel),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [27:0] disp(input logic [15:0] dig, input logic neg);
    logic [27:0] s;
    for (int i = 0; i < 4; i++) s[i*7 +: 7] = glyph(dig[i*4 +: 4]);
    if (neg) s[27:21] = 7'b0111111;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int unsigned n = 0;
    while (busy !== lvl && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy !== lvl) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: busy timeout, got %b, expected %b", name, busy, lvl);
    end
  endtask

  // Wait for a conversion that starts after the stimulus, check its busy
  // length, the held display in DONE, then pop and compare the result.
  task automatic conv_check(input string name, input logic chk_hold);
    int unsigned cyc;
    logic [27:0] exp;
    wait_busy(1'b0, name);
    wait_busy(1'b1, name);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check({name, " busy cycles"}, cyc, VAL_W + 1);
    if (chk_hold) check({name, " seg held in DONE"}, {4'h0, seg}, {4'h0, shown});
    @(negedge clock);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got 0x%h, expected an entry", name, seg);
    end else begin
      exp = exp_q.pop_front();
      check({name, " seg"}, {4'h0, seg}, {4'h0, exp});
      shown = exp;
    end
  endtask

  task automatic pulse_change();
    @(negedge clock);
    change = 1'b1;
    repeat (4) @(negedge clock);
    change = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    logic [1:0]  exp_ch;
    logic [15:0] ch_dig [3];

    vecs.push_back('{10'd359,   1'b0, 16'h0359, 1'b0});
    vecs.push_back('{10'h2AF,   1'b1, 16'h02AF, 1'b0});
    vecs.push_back('{10'd0,     1'b0, 16'h0000, 1'b0});
    vecs.push_back('{10'h3FF,   1'b1, 16'h03FF, 1'b0});
    vecs.push_back('{10'h3A6,   1'b1, 16'h03A6, 1'b0});
    vecs.push_back('{10'd511,   1'b0, 16'h0511, 1'b0});
    vecs.push_back('{10'h123,   1'b1, 16'h0123, 1'b0});
    vecs.push_back('{10'd99,    1'b0, 16'h0099, 1'b0});
    vecs.push_back('{10'h0CD,   1'b1, 16'h00CD, 1'b0});
    vecs.push_back('{10'd100,   1'b0, 16'h0100, 1'b0});
`ifdef HEX_BCD_SIGNED_EN
    vecs.push_back('{10'd1023,  1'b0, 16'h0001, 1'b1});
    vecs.push_back('{10'h3A6,   1'b0, 16'h0090, 1'b1});
    vecs.push_back('{10'h200,   1'b0, 16'h0512, 1'b1});
`else
    vecs.push_back('{10'd1023,  1'b0, 16'h1023, 1'b0});
    vecs.push_back('{10'h3A6,   1'b0, 16'h0934, 1'b0});
    vecs.push_back('{10'h200,   1'b0, 16'h0512, 1'b0});
`endif

    // Reset state
    #12;
    check("reset seg", {4'h0, seg}, {4'h0, ALL_BLANK});
    check("reset ch_sel", ch_sel, 2'd0);
    check("reset busy", busy, 1'b0);
    shown = ALL_BLANK;
    @(negedge clock);
    resetn = 1'b1;

    // Table-driven conversions on channel 0
    for (int i = 0; i < vecs.size(); i++) begin
      values   = {20'h0, vecs[i].val};
      hex_mode = vecs[i].hexm;
      exp_q.push_back(disp(vecs[i].dig, vecs[i].neg));
      conv_check($sformatf("vec%0d", i), 1'b1);
    end

    // Channel stepping with wrap
    ch_dig[0] = 16'h0111;
    ch_dig[1] = 16'h0222;
    ch_dig[2] = 16'h0333;
    values   = {10'd333, 10'd222, 10'd111};
    hex_mode = 1'b0;
    exp_q.push_back(disp(ch_dig[0], 1'b0));
    conv_check("chan0", 1'b1);
    exp_ch = 2'd0;
    for (int p = 1; p <= 3; p++) begin
      pulse_change();
      exp_ch = (exp_ch == 2'd2) ? 2'd0 : exp_ch + 2'd1;
      check($sformatf("pulse%0d ch_sel", p), ch_sel, exp_ch);
      exp_q.push_back(disp(ch_dig[exp_ch], 1'b0));
      conv_check($sformatf("pulse%0d", p), 1'b0);
    end

    // Abort mid-SHIFT: ch0=5 must never appear, ch1=77 shown
    @(negedge clock);
    resetn   = 1'b0;
    values   = {10'd333, 10'd77, 10'd5};
    hex_mode = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    shown  = ALL_BLANK;
    wait_busy(1'b1, "abort load");
    k = 0;
    repeat (3) begin
      @(negedge clock);
      k++;
    end
    change = 1'b1;
    exp_q.push_back(disp(16'h0077, 1'b0));
    while (seg === ALL_BLANK && k < 60) begin
      @(negedge clock);
      k++;
      if (k == 7) change = 1'b0;
    end
    change = 1'b0;
    check("abort latency", k, 18);
    check("abort ch_sel", ch_sel, 2'd1);
    check("abort seg", {4'h0, seg}, {4'h0, exp_q.pop_front()});

    // Reset during SHIFT, then channel 0 after release
    wait_busy(1'b0, "rst idle");
    wait_busy(1'b1, "rst load");
    repeat (4) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("midreset seg", {4'h0, seg}, {4'h0, ALL_BLANK});
    check("midreset ch_sel", ch_sel, 2'd0);
    check("midreset busy", busy, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    exp_q.push_back(disp(16'h0005, 1'b0));
    k = 0;
    while (seg === ALL_BLANK && k < 60) begin
      @(negedge clock);
      k++;
    end
    check("post-reset latency", k, VAL_W + 3);
    check("post-reset seg", {4'h0, seg}, {4'h0, exp_q.pop_front()});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
